// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the regfile write port (optional bypass: WB_ARB_FWD_EN)
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    output logic [DATA_WIDTH-1:0] data_writeReg,
    output logic                  last_grant,
`ifdef WB_ARB_FWD_EN
    input  logic [ADDR_WIDTH-1:0] fwd_readRegA,
    input  logic [ADDR_WIDTH-1:0] fwd_readRegB,
    output logic                  fwd_hitA,
    output logic                  fwd_hitB,
    output logic [DATA_WIDTH-1:0] fwd_data,
`endif
    output logic [7:0]            conflict_count
);

    typedef enum logic {
        G0 = 1'b0,
        G1 = 1'b1
    } grant_t;

    grant_t state;
    grant_t state_next;

    logic transfer;
    logic [ADDR_WIDTH-1:0] win_reg;
    logic [DATA_WIDTH-1:0] win_data;

    // Grant selection: a lone requester always wins; on conflict the one that did not win last time goes
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        win_reg    = req0_reg;
        win_data   = req0_data;
        if (req0_valid && (!req1_valid || state == G1)) begin
            req0_ready = 1'b1;
            state_next = G0;
        end else if (req1_valid) begin
            req1_ready = 1'b1;
            state_next = G1;
            win_reg    = req1_reg;
            win_data   = req1_data;
        end
    end

    assign transfer   = req0_ready || req1_ready;
    assign last_grant = (state == G1);

    // Grant history; reset to G1 so requester 0 wins the first conflict
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= G1;
        end else begin
            state <= state_next;
        end
    end

    // Output register: load the winner, suppress the enable for register 0, hold index/data when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (transfer) begin
            ctrl_writeEnable <= (win_reg != '0);
            ctrl_writeReg    <= win_reg;
            data_writeReg    <= win_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // Saturating count of cycles where both sources contend
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_count <= 8'd0;
        end else if (req0_valid && req1_valid && conflict_count != 8'hFF) begin
            conflict_count <= conflict_count + 8'd1;
        end
    end

`ifdef WB_ARB_FWD_EN
    // Bypass view of the write that the regfile has not yet captured
    always_comb begin
        fwd_hitA = ctrl_writeEnable && (ctrl_writeReg == fwd_readRegA);
        fwd_hitB = ctrl_writeEnable && (ctrl_writeReg == fwd_readRegB);
        fwd_data = data_writeReg;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        last_grant;
    logic [7:0]  conflict_count;
`ifdef WB_ARB_FWD_EN
    logic [4:0]  fwd_readRegA, fwd_readRegB;
    logic        fwd_hitA, fwd_hitB;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        e0;
        logic        e1;
        logic        elg;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[10];
    logic [4:0]  held_reg;
    logic [31:0] held_data;
    int          model_cc;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_reg(req0_reg),
        .req0_data(req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_reg(req1_reg),
        .req1_data(req1_data),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .last_grant(last_grant),
`ifdef WB_ARB_FWD_EN
        .fwd_readRegA(fwd_readRegA),
        .fwd_readRegB(fwd_readRegB),
        .fwd_hitA(fwd_hitA),
        .fwd_hitB(fwd_hitB),
        .fwd_data(fwd_data),
`endif
        .conflict_count(conflict_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        held_reg  = 5'd0;
        held_data = 32'd0;
        model_cc  = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        req0_valid = v.v0; req0_reg = v.r0; req0_data = v.d0;
        req1_valid = v.v1; req1_reg = v.r1; req1_data = v.d1;
        #3;
        check({tag, " req0_ready"}, 64'(req0_ready), 64'(v.e0));
        check({tag, " req1_ready"}, 64'(req1_ready), 64'(v.e1));
        if (v.e0) begin
            held_reg = v.r0; held_data = v.d0;
            e.we = (v.r0 != 5'd0);
        end else if (v.e1) begin
            held_reg = v.r1; held_data = v.d1;
            e.we = (v.r1 != 5'd0);
        end else begin
            e.we = 1'b0;
        end
        e.r = held_reg;
        e.d = held_data;
        sb.push_back(e);
        if (v.v0 && v.v1 && model_cc < 255) model_cc++;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " writeEnable"}, 64'(ctrl_writeEnable), 64'(e.we));
            check({tag, " writeReg"}, 64'(ctrl_writeReg), 64'(e.r));
            check({tag, " writeData"}, 64'(data_writeReg), 64'(e.d));
        end
        check({tag, " last_grant"}, 64'(last_grant), 64'(v.elg));
        check({tag, " conflict_count"}, 64'(conflict_count), 64'(model_cc));
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
`ifdef WB_ARB_FWD_EN
        fwd_readRegA = '0;
        fwd_readRegB = '0;
`endif
        model_reset();

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd7,  32'h00000077, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd7,  32'h00000077, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd7,  32'h00000077, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00001234, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 5'd0,  32'h0000AAAA, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 5'd12, 32'h12121212, 1'b1, 5'd12, 32'h34343434, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 5'd12, 32'h12121212, 1'b1, 5'd12, 32'h34343434, 1'b1, 1'b0, 1'b0};

        #2;
        check("reset writeEnable", 64'(ctrl_writeEnable), 64'd0);
        check("reset writeReg", 64'(ctrl_writeReg), 64'd0);
        check("reset writeData", 64'(data_writeReg), 64'd0);
        check("reset last_grant", 64'(last_grant), 64'd1);
        check("reset conflict_count", 64'(conflict_count), 64'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = '{1'b1, 5'd3, 32'h00000033, 1'b1, 5'd7, 32'h00000077,
                  (i % 2 == 0), (i % 2 == 1), (i % 2 == 1)};
            step(v, $sformatf("alt%0d", i));
        end
        check("alt conflict_count=4", 64'(conflict_count), 64'd4);

        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
        end
        #1;
        check("saturated conflict_count", 64'(conflict_count), 64'd255);

        do_reset();
        v = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0};
        step(v, "pre_rst");
`ifdef WB_ARB_FWD_EN
        fwd_readRegA = 5'd9;
        fwd_readRegB = 5'd10;
        #1;
        check("fwd_hitA", 64'(fwd_hitA), 64'd1);
        check("fwd_hitB", 64'(fwd_hitB), 64'd0);
        check("fwd_data", 64'(fwd_data), 64'hA5A5A5A5);
`endif
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst writeEnable", 64'(ctrl_writeEnable), 64'd0);
        check("midrst writeReg", 64'(ctrl_writeReg), 64'd0);
        check("midrst writeData", 64'(data_writeReg), 64'd0);
        check("midrst last_grant", 64'(last_grant), 64'd1);
        check("midrst conflict_count", 64'(conflict_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        v = '{1'b1, 5'd3, 32'h00000033, 1'b1, 5'd7, 32'h00000077, 1'b1, 1'b0, 1'b0};
        step(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback sources: the pipeline writeback stage (requester 0) and the multdiv unit (requester 1). Each source presents a valid/ready request carrying a target register and data. The block arbitrates round-robin and registers the winner onto the regfile write-port signals one cycle later. Writes to register 0 are accepted and consumed but never reach the regfile.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register index
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  pipeline writeback request
- req0_ready  out  1  grant to requester 0; transfer when valid && ready
- req0_reg  in  ADDR_WIDTH  target register, requester 0
- req0_data  in  DATA_WIDTH  write data, requester 0
- req1_valid, req1_ready, req1_reg, req1_data: same as requester 0, multdiv source
- ctrl_writeEnable  out  1  regfile write enable (registered)
- ctrl_writeReg  out  ADDR_WIDTH  regfile write index (registered)
- data_writeReg  out  DATA_WIDTH  regfile write data (registered)
- last_grant  out  1  index of the most recently granted requester
- conflict_count  out  8  saturating count of cycles with both requests valid
- fwd_readRegA, fwd_readRegB  in  ADDR_WIDTH  read indices to check (WB_ARB_FWD_EN only)
- fwd_hitA, fwd_hitB  out  1  pending write matches the read index (WB_ARB_FWD_EN only)
- fwd_data  out  DATA_WIDTH  data of the pending write (WB_ARB_FWD_EN only)

## Operation
- Ready is combinational from the valid inputs and last_grant; at most one ready is high per cycle.
- Only one requester is valid: that requester gets ready=1.
- Both are valid: the requester not equal to last_grant gets ready=1.
- Neither is valid: both readies are 0.
- A transfer is a cycle where valid && ready. On the clock edge of a transfer:
  - last_grant takes the winner's index.
  - The output register loads the winner's reg and data.
  - ctrl_writeEnable is set to 1 if reg != 0, else 0.
- No transfer on an edge: ctrl_writeEnable goes to 0. ctrl_writeReg and data_writeReg hold their values.
- Requesters hold valid, reg and data stable until granted. A requester that is not granted stays pending with no loss.
- There is no backpressure from the regfile: the write port accepts every cycle.
- conflict_count increments on every edge where both valids are high, and saturates at 255.
- State machine: a single bit, last_grant. Values are G0 (last grant was requester 0) and G1. Each transfer moves it to the winner; otherwise it holds.

## Timing
- Reset (asynchronous, immediate):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0
  - last_grant=1, so requester 0 wins the first conflict
  - conflict_count=0
  - fwd outputs=0
- Latency: a transfer at edge N drives ctrl_writeEnable during cycle N..N+1. The regfile captures the write at edge N+1.
- Throughput: one write per cycle.
- Under continuous conflict, grants strictly alternate 0,1,0,1. Worst-case wait for either requester is 1 cycle.
- Reset asserted mid-operation: the registered pending write is discarded. Any unacknowledged request is re-arbitrated after reset deasserts, from G1.
- Simultaneous writes to the same register from both sources are serialized in grant order. The later grant's data is the value that lands in the regfile.

## Configuration
- WB_ARB_FWD_EN defined:
  - fwd_hitA = ctrl_writeEnable && (ctrl_writeReg == fwd_readRegA). fwd_hitB is the same for fwd_readRegB.
  - fwd_data = data_writeReg.
  - All three are combinational from the output register. This lets decode bypass a write the regfile has not yet captured.
- WB_ARB_FWD_EN undefined: the fwd ports are absent from the module, and the output register alone is the block's behaviour.

## Test plan
- Reset, then req0 only with reg=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; last_grant=0.
- Both valid for 4 cycles straight after reset (req0 reg=3, req1 reg=7) -> grants 0,1,0,1; conflict_count=4; output register alternates reg 3 and reg 7.
- req1 with reg=0, data=0x1234 -> req1_ready=1; next cycle ctrl_writeEnable=0; last_grant=1.
- Hold both valid for 300 cycles -> conflict_count stops at 255.
- Assert reset while ctrl_writeEnable=1 -> all outputs 0 immediately; after release with both valid, requester 0 is granted first.
- With WB_ARB_FWD_EN defined: pending write reg=9, data=0xA5A5A5A5, fwd_readRegA=9, fwd_readRegB=10 -> fwd_hitA=1, fwd_hitB=0, fwd_data=0xA5A5A5A5.
